// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared state encoding, request types and counter helpers
package data_memory_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;
    localparam int   CNT_W     = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/data_memory_responder_ram.sv
// dmr_ram_array: single-port word array, synchronous write, asynchronous read
module dmr_ram_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Contents are deliberately not reset; stores land on the clock edge
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency load/store responder with valid/ready response channel
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [CNT_W-1:0]      load_count,
    output logic [CNT_W-1:0]      store_count
);

    state_t                state;
    logic [3:0]            cnt;
    logic                  hold_write;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [CNT_W-1:0]      load_cnt;
    logic [CNT_W-1:0]      store_cnt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] accept_data;

    assign req_ready   = (state == ST_IDLE);
    assign accept      = req_ready && req_valid;
    assign accept_data = (req_write == REQ_STORE) ? '0 : ram_rdata;
    assign load_count  = load_cnt;
    assign store_count = store_cnt;

    dmr_ram_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (accept && (req_write == REQ_STORE)),
        .addr (req_addr),
        .wdata(req_wdata),
        .rdata(ram_rdata)
    );

    // Request/response FSM: capture at accept, count out the latency, hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hold_write <= 1'b0;
            hold_data  <= '0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        hold_write <= req_write;
                        hold_data  <= accept_data;
                        if (LATENCY == 1) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_write <= req_write;
                            resp_rdata <= accept_data;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_write <= hold_write;
                        resp_rdata <= hold_data;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completed-transfer statistics, saturating at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            store_cnt <= '0;
        end else if (state == ST_RESP && resp_ready) begin
            if (resp_write == REQ_LOAD) load_cnt <= sat_inc(load_cnt);
            else                        store_cnt <= sat_inc(store_cnt);
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed, table-driven checks of the data memory responder
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n, req_valid, req_ready, req_write, resp_valid, resp_ready, resp_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata, resp_rdata;
    logic [15:0] load_count, store_count;

    logic        b_rst_n, b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_write;
    logic [7:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_resp_rdata;
    logic [15:0] b_load_count, b_store_count;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_lc = 16'd0;
    logic [15:0] exp_sc = 16'd0;

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .load_count(load_count), .store_count(store_count)
    );

    data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_write(b_resp_write),
        .resp_rdata(b_resp_rdata), .load_count(b_load_count), .store_count(b_store_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start(input logic w, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic finish_resp(input logic w);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        if (w) exp_sc = (exp_sc == 16'hFFFF) ? exp_sc : exp_sc + 16'd1;
        else   exp_lc = (exp_lc == 16'hFFFF) ? exp_lc : exp_lc + 16'd1;
    endtask

    task automatic run(input string name, input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd);
        int lat;
        start(w, a, d);
        wait_resp(lat);
        check({name, "_latency"}, lat, 32'd2);
        check({name, "_rdata"}, resp_rdata, exp_rd);
        check({name, "_write"}, {31'b0, resp_write}, {31'b0, w});
        finish_resp(w);
        check({name, "_valid_clear"}, {31'b0, resp_valid}, 32'd0);
        check({name, "_load_count"}, {16'b0, load_count}, {16'b0, exp_lc});
        check({name, "_store_count"}, {16'b0, store_count}, {16'b0, exp_sc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        vecs[0] = '{1'b0, 8'd1, 32'h0,        32'hABCDABCD};
        vecs[1] = '{1'b1, 8'd1, 32'hEFEFEFEF, 32'h0};
        vecs[2] = '{1'b0, 8'd1, 32'h0,        32'hEFEFEFEF};
        vecs[3] = '{1'b1, 8'd5, 32'h12345678, 32'h0};
        vecs[4] = '{1'b0, 8'd5, 32'h0,        32'h12345678};
        vecs[5] = '{1'b0, 8'd7, 32'h0,        32'h77770000};

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_resp_ready = 1'b1;
        dut.u_ram.mem[1]  = 32'hABCDABCD;
        dut.u_ram.mem[7]  = 32'h77770000;
        dut1.u_ram.mem[0] = 32'h11111111;
        dut1.u_ram.mem[1] = 32'h22222222;
        dut1.u_ram.mem[2] = 32'h33333333;
        #12;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_write", {31'b0, resp_write}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_load_count", {16'b0, load_count}, 32'd0);
        check("rst_store_count", {16'b0, store_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        b_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd);

        // response held under backpressure while a second request waits
        start(1'b0, 8'd5, 32'h0);
        wait_resp(lat);
        check("hold_latency", lat, 32'd2);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd6; req_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_valid%0d", i), {31'b0, resp_valid}, 32'd1);
            check($sformatf("hold_rdata%0d", i), resp_rdata, 32'h12345678);
            check($sformatf("hold_req_ready%0d", i), {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        exp_lc = exp_lc + 16'd1;
        check("hold_done_valid", {31'b0, resp_valid}, 32'd0);
        check("hold_done_rdata", resp_rdata, 32'd0);
        check("hold_done_req_ready", {31'b0, req_ready}, 32'd1);
        check("hold_done_load_count", {16'b0, load_count}, {16'b0, exp_lc});
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("second_accepted", {31'b0, req_ready}, 32'd0);
        wait_resp(lat);
        check("second_latency", lat, 32'd2);
        check("second_write", {31'b0, resp_write}, 32'd1);
        check("second_rdata", resp_rdata, 32'd0);
        finish_resp(1'b1);
        run("load6", 1'b0, 8'd6, 32'h0, 32'hDEADBEEF);

        // asynchronous reset during the wait phase of a load
        run("store4", 1'b1, 8'd4, 32'h44444444, 32'h0);
        start(1'b0, 8'd3, 32'h0);
        check("wait_no_valid", {31'b0, resp_valid}, 32'd0);
        check("wait_not_ready", {31'b0, req_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("mid_rst_load_count", {16'b0, load_count}, 32'd0);
        check("mid_rst_store_count", {16'b0, store_count}, 32'd0);
        exp_lc = 16'd0;
        exp_sc = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_no_resp%0d", i), {31'b0, resp_valid}, 32'd0);
        end
        run("load4", 1'b0, 8'd4, 32'h0, 32'h44444444);

        // LATENCY=1 instance: back-to-back loads with resp_ready tied high
        @(negedge clk);
        b_req_valid = 1'b1;
        b_req_write = 1'b0;
        b_req_addr  = 8'd0;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_d;
            exp_d = (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 : 32'h33333333;
            @(posedge clk);
            #1;
            check($sformatf("l1_valid%0d", i), {31'b0, b_resp_valid}, 32'd1);
            check($sformatf("l1_rdata%0d", i), b_resp_rdata, exp_d);
            check($sformatf("l1_busy%0d", i), {31'b0, b_req_ready}, 32'd0);
            b_req_addr = 8'(i + 1);
            if (i == 2) b_req_valid = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("l1_gap_valid%0d", i), {31'b0, b_resp_valid}, 32'd0);
            check($sformatf("l1_gap_ready%0d", i), {31'b0, b_req_ready}, 32'd1);
        end
        check("l1_load_count", {16'b0, b_load_count}, 32'd3);

        // saturation of the load counter
        @(negedge clk);
        dut.load_cnt = 16'hFFFE;
        exp_lc = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            run($sformatf("sat%0d", i), 1'b0, 8'd4, 32'h0, 32'h44444444);
            check($sformatf("sat_value%0d", i), {16'b0, load_count}, 32'h0000FFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
